// File: rtl/des_decryption_iterative.sv
// ---------------------------------------------------------------------------
// des_decryption_iterative
//
// Iterative DES decryption core. A block is taken on start. The core then
// runs the 16 Feistel rounds with the keys in reverse order (K16 first). It
// evaluates ROUNDS_PER_CYCLE chained rounds per clock. At the end it applies
// IP^-1 to the swapped halves, registers the plaintext and pulses done.
//
// DES numbers bits 1..64 from the MSB. The vectors in this file are
// descending, so DES bit n of a W-bit word is vector bit [W-n].
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       request; ciphertext is valid in the same cycle
//   ciphertext  64-bit block to decrypt (bit 63 = DES bit 1)
//   round_keys  768-bit key bus: K1 in [767:720], K2 in [719:672], ...,
//               K16 in [47:0]. It is not latched and must stay stable
//               until done.
//   busy        high while rounds are in progress
//   done        single-cycle pulse; result is valid from this cycle
//   result      registered plaintext; held until the next completion
// ---------------------------------------------------------------------------
module des_decryption_iterative #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [63:0]  ciphertext,
    input  logic [767:0] round_keys,
    output logic         busy,
    output logic         done,
    output logic [63:0]  result
);

    generate
        if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4)) begin : g_bad_param
            $error("des_decryption_iterative: ROUNDS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [3:0] STEP     = 4'(ROUNDS_PER_CYCLE);
    localparam logic [3:0] LAST_CNT = 4'(16 - ROUNDS_PER_CYCLE);

    // Permutation tables. Entries are 1-based DES bit positions of the source.
    localparam int IP_TBL [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7
    };
    localparam int IPI_TBL [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25
    };
    localparam int E_TBL [48] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1
    };
    localparam int P_TBL [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25
    };

    // S-boxes. Each box is 64 nibbles, entry (row*16 + col) first from the MSB.
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    function automatic logic [63:0] ip_perm(input logic [63:0] d);
        logic [63:0] o;
        o = '0;
        for (int k = 0; k < 64; k++) begin
            o[63-k] = d[64-IP_TBL[k]];
        end
        return o;
    endfunction

    function automatic logic [63:0] ip_inv_perm(input logic [63:0] d);
        logic [63:0] o;
        o = '0;
        for (int k = 0; k < 64; k++) begin
            o[63-k] = d[64-IPI_TBL[k]];
        end
        return o;
    endfunction

    // f(R, K) = P(S(E(R) ^ K))
    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] key);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] o;
        logic [5:0]  six;
        int          idx;
        x = '0;
        s = '0;
        o = '0;
        for (int k = 0; k < 48; k++) begin
            x[47-k] = r[32-E_TBL[k]];
        end
        x = x ^ key;
        for (int i = 0; i < 8; i++) begin
            six = x[47-6*i -: 6];
            // Outer bits pick the row, inner four bits pick the column.
            idx = int'({six[5], six[0], six[4:1]});
            s[31-4*i -: 4] = SBOX[i][255-4*idx -: 4];
        end
        for (int k = 0; k < 32; k++) begin
            o[31-k] = s[32-P_TBL[k]];
        end
        return o;
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

    state_t      state_reg;
    logic [31:0] l_reg;
    logic [31:0] r_reg;
    logic [3:0]  round_cnt_reg;

    logic [63:0] ip_ct;
    logic [31:0] l_last;
    logic [31:0] r_last;

    assign ip_ct = ip_perm(ciphertext);

    // Combinational chain of ROUNDS_PER_CYCLE rounds. Round i takes K(16-i).
    // K(16-i) sits at round_keys[48*i +: 48], so the slice base grows with i.
    for (genvar gi = 0; gi < ROUNDS_PER_CYCLE; gi++) begin : g_round
        logic [31:0] l_in;
        logic [31:0] r_in;
        logic [31:0] l_out;
        logic [31:0] r_out;
        logic [3:0]  idx;
        logic [47:0] rkey;

        if (gi == 0) begin : g_first
            assign l_in = l_reg;
            assign r_in = r_reg;
        end else begin : g_next
            assign l_in = g_round[gi-1].l_out;
            assign r_in = g_round[gi-1].r_out;
        end

        assign idx   = round_cnt_reg + 4'(gi);
        assign rkey  = round_keys[48*int'(idx) +: 48];
        assign l_out = r_in;
        assign r_out = l_in ^ feistel(r_in, rkey);
    end

    assign l_last = g_round[ROUNDS_PER_CYCLE-1].l_out;
    assign r_last = g_round[ROUNDS_PER_CYCLE-1].r_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            l_reg         <= '0;
            r_reg         <= '0;
            round_cnt_reg <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            result        <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        {l_reg, r_reg} <= ip_ct;
                        round_cnt_reg  <= '0;
                        busy           <= 1'b1;
                        state_reg      <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    // start is ignored here; only the round datapath advances.
                    l_reg         <= l_last;
                    r_reg         <= r_last;
                    round_cnt_reg <= round_cnt_reg + STEP;
                    if (round_cnt_reg == LAST_CNT) begin
                        // Output is IP^-1 of the swapped halves {R16, L16}.
                        result    <= ip_inv_perm({r_last, l_last});
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= S_DONE;
                    end
                end
                S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Back-to-back accept with no idle cycle in between.
                        {l_reg, r_reg} <= ip_ct;
                        round_cnt_reg  <= '0;
                        busy           <= 1'b1;
                        state_reg      <= S_ROUND;
                    end else begin
                        state_reg <= S_IDLE;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_des_decryption_iterative.sv
// ---------------------------------------------------------------------------
// tb_des_decryption_iterative
//
// Directed bench for des_decryption_iterative. It builds three instances with
// ROUNDS_PER_CYCLE = 1, 2 and 4. A reference DES key schedule and encryptor
// produce the ciphertexts. Expected plaintexts are queued when a block is
// started and popped when the instance pulses done.
// ---------------------------------------------------------------------------
module tb_des_decryption_iterative;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start1, start2, start4;
    logic [63:0]  ct;
    logic [767:0] rk;
    logic         busy1, busy2, busy4;
    logic         done1, done2, done4;
    logic [63:0]  res1, res2, res4;

    always #5 clk = ~clk;

    des_decryption_iterative #(.ROUNDS_PER_CYCLE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .ciphertext(ct), .round_keys(rk),
        .busy(busy1), .done(done1), .result(res1)
    );
    des_decryption_iterative #(.ROUNDS_PER_CYCLE(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .ciphertext(ct), .round_keys(rk),
        .busy(busy2), .done(done2), .result(res2)
    );
    des_decryption_iterative #(.ROUNDS_PER_CYCLE(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .ciphertext(ct), .round_keys(rk),
        .busy(busy4), .done(done4), .result(res4)
    );

    // ---------------- reference DES model (right-aligned words) ----------------
    localparam int M_IP [64] = '{
        58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
        57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7
    };
    localparam int M_IPI [64] = '{
        40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
        36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25
    };
    localparam int M_E [64] = '{
        32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
        16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1,
        0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0
    };
    localparam int M_P [64] = '{
        16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10, 2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25,
        0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0
    };
    localparam int M_PC1 [64] = '{
        57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
        63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4,
        0,0,0,0,0,0,0,0
    };
    localparam int M_PC2 [64] = '{
        14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
        41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32,
        0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0
    };
    localparam int M_SHIFT [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    localparam logic [255:0] M_SB [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    // DES bit n of an in_w-wide right-aligned word is bit [in_w-n].
    function automatic logic [63:0] permute(input logic [63:0] din, input int in_w,
                                            input int out_w, input int tbl [64]);
        logic [63:0] o;
        o = '0;
        for (int k = 0; k < out_w; k++) o[out_w-1-k] = din[in_w-tbl[k]];
        return o;
    endfunction

    function automatic logic [767:0] key_sched(input logic [63:0] key);
        logic [63:0]  t;
        logic [27:0]  c, d;
        logic [767:0] ks;
        ks = '0;
        t = permute(key, 64, 56, M_PC1);
        c = t[55:28];
        d = t[27:0];
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < M_SHIFT[r]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            t = permute({8'h00, c, d}, 56, 48, M_PC2);
            ks[767-48*r -: 48] = t[47:0];
        end
        return ks;
    endfunction

    function automatic logic [31:0] model_f(input logic [31:0] r, input logic [47:0] k);
        logic [63:0] t;
        logic [47:0] x;
        logic [31:0] s;
        logic [5:0]  six;
        int          idx;
        s = '0;
        t = permute({32'h0, r}, 32, 48, M_E);
        x = t[47:0] ^ k;
        for (int i = 0; i < 8; i++) begin
            six = x[47-6*i -: 6];
            idx = 16 * int'({six[5], six[0]}) + int'(six[4:1]);
            s[31-4*i -: 4] = M_SB[i][255-4*idx -: 4];
        end
        t = permute({32'h0, s}, 32, 32, M_P);
        return t[31:0];
    endfunction

    function automatic logic [63:0] des_encrypt(input logic [63:0] pt, input logic [767:0] ks);
        logic [63:0] t;
        logic [31:0] l, r, tmp;
        t = permute(pt, 64, 64, M_IP);
        l = t[63:32];
        r = t[31:0];
        for (int i = 0; i < 16; i++) begin
            tmp = r;
            r   = l ^ model_f(r, ks[767-48*i -: 48]);
            l   = tmp;
        end
        return permute({r, l}, 64, 64, M_IPI);
    endfunction

    // ---------------- scoreboard and checking ----------------
    int          total = 0;
    int          bad = 0;
    logic [63:0] exp_q [$];
    int          done_cnt1 = 0;
    int          busy_cnt1 = 0;

    always @(negedge clk) begin
        if (done1) done_cnt1 <= done_cnt1 + 1;
        if (busy1) busy_cnt1 <= busy_cnt1 + 1;
    end

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic done_of(input int sel);
        case (sel)
            2:       return done2;
            4:       return done4;
            default: return done1;
        endcase
    endfunction

    function automatic logic [63:0] res_of(input int sel);
        case (sel)
            2:       return res2;
            4:       return res4;
            default: return res1;
        endcase
    endfunction

    task automatic set_start(input int sel, input logic v);
        case (sel)
            2:       start2 = v;
            4:       start4 = v;
            default: start1 = v;
        endcase
    endtask

    // Drive one start pulse; the following rising edge is the accepting edge.
    task automatic accept(input int sel, input logic [63:0] c, input logic [63:0] pt);
        exp_q.push_back(pt);
        ct = c;
        set_start(sel, 1'b1);
        @(posedge clk);
        #1;
        set_start(sel, 1'b0);
    endtask

    // Count falling edges until done, check that count, then pop and compare.
    task automatic wait_done(input int sel, input string tag, input int exp_n);
        int          n;
        logic        got;
        logic [63:0] expv;
        n   = 0;
        got = 1'b0;
        while (n < 60 && !got) begin
            @(negedge clk);
            n++;
            got = done_of(sel);
        end
        check_int({tag, "_latency"}, got ? n : -1, exp_n);
        if (exp_q.size() == 0) begin
            expv = 'x;
        end else begin
            expv = exp_q.pop_front();
        end
        check64({tag, "_result"}, res_of(sel), expv);
        $display("txn %s rpc=%0d ct=%h result=%h expected=%h cycles=%0d", tag, sel, ct, res_of(sel), expv, n);
    endtask

    initial begin
        logic [767:0] ks;
        logic [63:0]  pt_a, pt_b, c_a, c_b, key;
        int           dbase, bbase;

        rst_n  = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        start4 = 1'b0;
        ct     = '0;
        rk     = '0;
        repeat (3) @(posedge clk);
        #1;
        check_int("reset_busy", int'(busy1), 0);
        check_int("reset_done", int'(done1), 0);
        check64("reset_result", res1, 64'h0);
        check64("reset_result_rpc4", res4, 64'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // All-zero key schedule.
        rk    = '0;
        dbase = done_cnt1;
        bbase = busy_cnt1;
        accept(1, 64'h8CA64DE9C1B123A7, 64'h0);
        wait_done(1, "zero_keys", 17);
        @(posedge clk);
        #1;
        check_int("zero_keys_busy_cycles", busy_cnt1 - bbase, 16);
        check_int("zero_keys_done_pulses", done_cnt1 - dbase, 1);

        // Classic known-answer vector on all three widths.
        rk = key_sched(64'h133457799BBCDFF1);
        accept(1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF);
        wait_done(1, "kat_rpc1", 17);
        accept(2, 64'h85E813540F0AB405, 64'h0123456789ABCDEF);
        wait_done(2, "kat_rpc2", 9);
        accept(4, 64'h85E813540F0AB405, 64'h0123456789ABCDEF);
        wait_done(4, "kat_rpc4", 5);

        // Back-to-back: the second start is raised during the DONE cycle.
        rk   = '0;
        pt_a = 64'hDEADBEEF01234567;
        accept(1, des_encrypt(pt_a, rk), pt_a);
        wait_done(1, "b2b_first", 17);
        accept(1, 64'h8CA64DE9C1B123A7, 64'h0);
        wait_done(1, "b2b_second", 17);
        @(posedge clk);
        #1;

        // start during ROUND is ignored; the ciphertext also changes afterwards.
        key  = 64'h0E329232EA6D0D73;
        ks   = key_sched(key);
        rk   = ks;
        pt_a = 64'h8787878787878787;
        c_a  = des_encrypt(pt_a, ks);
        dbase = done_cnt1;
        accept(1, c_a, pt_a);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        ct     = 64'h1122334455667788;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        wait_done(1, "ignored_start", 12);
        repeat (20) @(posedge clk);
        #1;
        check_int("ignored_start_done_pulses", done_cnt1 - dbase, 1);

        // Reset in the middle of a block.
        pt_b = 64'h0F1E2D3C4B5A6978;
        c_b  = des_encrypt(pt_b, ks);
        accept(1, c_b, pt_b);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #2;
        check_int("abort_busy", int'(busy1), 0);
        check_int("abort_done", int'(done1), 0);
        check64("abort_result", res1, 64'h0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        dbase = done_cnt1;
        repeat (25) @(posedge clk);
        #1;
        check_int("abort_no_done", done_cnt1 - dbase, 0);
        accept(1, c_b, pt_b);
        wait_done(1, "after_abort", 17);

        // Random round trips through the reference encryptor.
        for (int i = 0; i < 1000; i++) begin
            key  = {$urandom(), $urandom()};
            pt_a = {$urandom(), $urandom()};
            ks   = key_sched(key);
            rk   = ks;
            accept(1, des_encrypt(pt_a, ks), pt_a);
            wait_done(1, "round_trip", 17);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
